ysyx_23060191_csr_ctrl: RTL and testbench
=========================================

// Module: ysyx_23060191_csr_ctrl
// PURPOSE
//  Initiator side of the CSR register-file port: executes CSRRW/S/C(I), ECALL and MRET for the core.
//  Accepts one request, reads the old CSR value, computes and issues the write, then returns rd data and PC redirect.
//  Sits between decode/execute and the CSR register file (mtvec 0x305, mepc 0x341, mstatus 0x300, mcause 0x342).
// PARAMETERS
//  CPU_WIDTH  32  data/PC width
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst          in   1          asynchronous, active-high reset
//  req_valid    in   1          request present
//  req_ready    out  1          1 only in IDLE
//  is_csr       in   1          Zicsr instruction
//  is_ecall     in   1          ECALL
//  is_mret      in   1          MRET
//  funct3       in   3          001 RW,010 RS,011 RC,101 RWI,110 RSI,111 RCI
//  csr_addr     in   12         target CSR address
//  rs1_idx      in   5          rs1 index; also zimm for *I forms
//  rs1_data     in   CPU_WIDTH  rs1 value
//  pc           in   CPU_WIDTH  PC of request
//  a5_data      in   CPU_WIDTH  ecall event number
//  addr_rd_csr  out  12         CSR read address
//  data_rd_csr  in   CPU_WIDTH  CSR read data (combinational)
//  wr_en_csr    out  1          CSR write strobe
//  addr_wr_csr  out  12         CSR write address
//  data_wr_csr  out  CPU_WIDTH  CSR write data / PC for ecall
//  ecall_en     out  1          trap strobe to CSR file
//  ecall_NO     out  CPU_WIDTH  mcause value
//  mtvec, mepc  in   CPU_WIDTH  live CSR values
//  resp_valid   out  1          result present
//  resp_ready   in   1          core accepts result
//  rd_we        out  1          write rd_wdata to rd
//  rd_wdata     out  CPU_WIDTH  old CSR value
//  redir_valid  out  1          redirect PC (qualified by resp_valid)
//  redir_pc     out  CPU_WIDTH  new PC
//  illegal      out  1          request rejected, no side effects
// BEHAVIOUR
//  States IDLE, READ, WRITE, TRAP, RET, RESP. Reset (async): state IDLE, every output and latch 0.
//  IDLE: req_valid&req_ready latches all inputs. is_csr->READ; is_ecall->TRAP; is_mret->RET.
//   Not exactly one of is_* set, bad funct3, or csr_addr outside the four -> RESP, illegal=1.
//  READ (1 cyc): addr_rd_csr=latched addr; old<=data_rd_csr. src=rs1_data or zext(zimm) for *I.
//   new: RW=src, RS=old|src, RC=old&~src. Write skipped for RS/RC/RSI/RCI when rs1_idx==0,
//   and always for 0x300 (mstatus is fixed 0x1800) -> straight to RESP; else -> WRITE.
//  WRITE (1 cyc): wr_en_csr=1, addr_wr_csr=addr, data_wr_csr=new -> RESP.
//  TRAP (1 cyc): ecall_en=1, ecall_NO=a5_data, data_wr_csr=pc; redir_pc<=mtvec (pre-edge) -> RESP.
//  RET (1 cyc): redir_pc<=mepc -> RESP. No CSR write.
//  RESP: resp_valid=1, holds outputs stable until resp_ready; then IDLE same edge.
//   rd_we=1 with rd_wdata=old for legal CSR ops (core discards when rd=x0); redir_valid for ECALL/MRET.
//  Latency req accept->resp_valid: CSR write 3, CSR no-write 2, ECALL/MRET 2, illegal 1 cycles.
//  wr_en_csr/ecall_en are single-cycle pulses, never both high; never high outside WRITE/TRAP.
//  Reset mid-operation: aborts; strobes drop asynchronously, no partial write.
//  No new request accepted until RESP handshake completes; back-to-back requests allowed next cycle.
// TESTING
//  CSRRW 0x305, rs1=0x8000_0100, old 0 -> wr_en 1 cyc at 0x305 data 0x8000_0100; rd_wdata 0; lat 3.
//  CSRRS 0x342, rs1_idx=0 -> no wr_en; rd_wdata=mcause; latency 2.
//  CSRRCI 0x341 zimm=3, mepc=0x8000_0007 -> write 0x8000_0004; CSRRW 0x300 -> no write, rd 0x1800.
//  ECALL pc=0x8000_0040 a5=11 mtvec=0x8000_1000 -> ecall_en 1 cyc, ecall_NO 11, data 0x8000_0040, redir 0x8000_1000.
//  MRET mepc=0x8000_0044 -> redir_pc 0x8000_0044, no strobes; hold resp_ready=0 5 cyc -> outputs stable.
//  csr_addr 0x7C0 -> illegal=1 after 1 cyc, no strobes; rst asserted in WRITE -> wr_en drops, state IDLE.

Source files
------------

// File: rtl/ysyx_23060191_csr_ctrl.sv
// CSR access controller: runs CSRRW/S/C(I), ECALL and MRET against the
// CSR register file and hands the rd value / PC redirect back to the core.
module ysyx_23060191_csr_ctrl #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    // request side
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 is_csr,
    input  logic                 is_ecall,
    input  logic                 is_mret,
    input  logic [2:0]           funct3,
    input  logic [11:0]          csr_addr,
    input  logic [4:0]           rs1_idx,
    input  logic [CPU_WIDTH-1:0] rs1_data,
    input  logic [CPU_WIDTH-1:0] pc,
    input  logic [CPU_WIDTH-1:0] a5_data,
    // CSR register file port
    output logic [11:0]          addr_rd_csr,
    input  logic [CPU_WIDTH-1:0] data_rd_csr,
    output logic                 wr_en_csr,
    output logic [11:0]          addr_wr_csr,
    output logic [CPU_WIDTH-1:0] data_wr_csr,
    output logic                 ecall_en,
    output logic [CPU_WIDTH-1:0] ecall_NO,
    input  logic [CPU_WIDTH-1:0] mtvec,
    input  logic [CPU_WIDTH-1:0] mepc,
    // response side
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 rd_we,
    output logic [CPU_WIDTH-1:0] rd_wdata,
    output logic                 redir_valid,
    output logic [CPU_WIDTH-1:0] redir_pc,
    output logic                 illegal
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_TRAP  = 3'd3;
    localparam logic [2:0] S_RET   = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    logic [2:0]           state;

    // request fields captured on accept
    logic [11:0]          addr_q;
    logic [2:0]           f3_q;
    logic [4:0]           rs1_idx_q;
    logic [CPU_WIDTH-1:0] rs1_q;
    logic [CPU_WIDTH-1:0] pc_q;
    logic [CPU_WIDTH-1:0] a5_q;

    // results
    logic [CPU_WIDTH-1:0] old_q;
    logic [CPU_WIDTH-1:0] new_q;
    logic [CPU_WIDTH-1:0] redir_q;
    logic                 op_csr_q;
    logic                 op_redir_q;
    logic                 illegal_q;

    logic                 accept;
    logic                 one_hot;
    logic                 f3_ok;
    logic                 addr_ok;
    logic                 req_legal;
    logic [CPU_WIDTH-1:0] src;
    logic [CPU_WIDTH-1:0] new_val;
    logic                 skip_wr;

    assign accept = req_valid && req_ready;

    // request legality: exactly one op kind, and for Zicsr a known funct3 and CSR
    always_comb begin
        one_hot = 1'b0;
        case ({is_csr, is_ecall, is_mret})
            3'b100, 3'b010, 3'b001: one_hot = 1'b1;
            default:                one_hot = 1'b0;
        endcase
        f3_ok   = (funct3[1:0] != 2'b00);
        addr_ok = (csr_addr == A_MSTATUS) || (csr_addr == A_MTVEC) ||
                  (csr_addr == A_MEPC)    || (csr_addr == A_MCAUSE);
        req_legal = one_hot && (!is_csr || (f3_ok && addr_ok));
    end

    // new CSR value from the freshly read old value and the rs1/zimm source
    always_comb begin
        src = f3_q[2] ? {{(CPU_WIDTH-5){1'b0}}, rs1_idx_q} : rs1_q;
        case (f3_q[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = data_rd_csr | src;
            default: new_val = data_rd_csr & ~src;
        endcase
        // set/clear with x0 source must not write; mstatus is read-only here
        skip_wr = (addr_q == A_MSTATUS) || (f3_q[1] && (rs1_idx_q == 5'd0));
    end

    // control FSM and all captured state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            f3_q       <= '0;
            rs1_idx_q  <= '0;
            rs1_q      <= '0;
            pc_q       <= '0;
            a5_q       <= '0;
            old_q      <= '0;
            new_q      <= '0;
            redir_q    <= '0;
            op_csr_q   <= 1'b0;
            op_redir_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q     <= csr_addr;
                        f3_q       <= funct3;
                        rs1_idx_q  <= rs1_idx;
                        rs1_q      <= rs1_data;
                        pc_q       <= pc;
                        a5_q       <= a5_data;
                        old_q      <= '0;
                        new_q      <= '0;
                        redir_q    <= '0;
                        illegal_q  <= !req_legal;
                        op_csr_q   <= req_legal && is_csr;
                        op_redir_q <= req_legal && (is_ecall || is_mret);
                        if (!req_legal)
                            state <= S_RESP;
                        else if (is_csr)
                            state <= S_READ;
                        else if (is_ecall)
                            state <= S_TRAP;
                        else
                            state <= S_RET;
                    end
                end
                S_READ: begin
                    old_q <= data_rd_csr;
                    new_q <= new_val;
                    state <= skip_wr ? S_RESP : S_WRITE;
                end
                S_WRITE: begin
                    state <= S_RESP;
                end
                S_TRAP: begin
                    redir_q <= mtvec;
                    state   <= S_RESP;
                end
                S_RET: begin
                    redir_q <= mepc;
                    state   <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready)
                        state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // outputs are pure state decodes, so reset drops every strobe at once
    always_comb begin
        req_ready   = (state == S_IDLE) && !rst;
        addr_rd_csr = '0;
        wr_en_csr   = 1'b0;
        addr_wr_csr = '0;
        data_wr_csr = '0;
        ecall_en    = 1'b0;
        ecall_NO    = '0;
        resp_valid  = 1'b0;
        rd_we       = 1'b0;
        rd_wdata    = '0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        illegal     = 1'b0;
        case (state)
            S_READ: begin
                addr_rd_csr = addr_q;
            end
            S_WRITE: begin
                wr_en_csr   = 1'b1;
                addr_wr_csr = addr_q;
                data_wr_csr = new_q;
            end
            S_TRAP: begin
                ecall_en    = 1'b1;
                ecall_NO    = a5_q;
                data_wr_csr = pc_q;
            end
            S_RESP: begin
                resp_valid  = 1'b1;
                rd_we       = op_csr_q;
                rd_wdata    = old_q;
                redir_valid = op_redir_q;
                redir_pc    = redir_q;
                illegal     = illegal_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060191_csr_ctrl.sv
// Testbench for ysyx_23060191_csr_ctrl: a small CSR-file environment plus a
// transaction-level reference model of the instruction semantics.
module tb_ysyx_23060191_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, is_csr, is_ecall, is_mret;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data, pc, a5_data;
    logic [11:0] addr_rd_csr, addr_wr_csr;
    logic [31:0] data_rd_csr, data_wr_csr, ecall_NO, mtvec, mepc;
    logic        wr_en_csr, ecall_en, resp_valid, resp_ready, rd_we, redir_valid, illegal;
    logic [31:0] rd_wdata, redir_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_23060191_csr_ctrl #(.CPU_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_csr(is_csr), .is_ecall(is_ecall), .is_mret(is_mret),
        .funct3(funct3), .csr_addr(csr_addr), .rs1_idx(rs1_idx),
        .rs1_data(rs1_data), .pc(pc), .a5_data(a5_data),
        .addr_rd_csr(addr_rd_csr), .data_rd_csr(data_rd_csr),
        .wr_en_csr(wr_en_csr), .addr_wr_csr(addr_wr_csr), .data_wr_csr(data_wr_csr),
        .ecall_en(ecall_en), .ecall_NO(ecall_NO),
        .mtvec(mtvec), .mepc(mepc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .rd_we(rd_we), .rd_wdata(rd_wdata),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .illegal(illegal)
    );

    // CSR register file environment (mstatus reads as fixed 0x1800)
    logic [31:0] f_mtvec, f_mepc, f_mcause;
    logic        pl_en = 1'b0;
    logic [31:0] pl_mtvec, pl_mepc, pl_mcause;

    always_comb begin
        case (addr_rd_csr)
            12'h300: data_rd_csr = 32'h0000_1800;
            12'h305: data_rd_csr = f_mtvec;
            12'h341: data_rd_csr = f_mepc;
            12'h342: data_rd_csr = f_mcause;
            default: data_rd_csr = 32'h0;
        endcase
    end
    assign mtvec = f_mtvec;
    assign mepc  = f_mepc;

    always @(posedge clk) begin
        if (pl_en) begin
            f_mtvec  <= pl_mtvec;
            f_mepc   <= pl_mepc;
            f_mcause <= pl_mcause;
        end else begin
            if (wr_en_csr) begin
                case (addr_wr_csr)
                    12'h305: f_mtvec  <= data_wr_csr;
                    12'h341: f_mepc   <= data_wr_csr;
                    12'h342: f_mcause <= data_wr_csr;
                    default: ;
                endcase
            end
            if (ecall_en) begin
                f_mepc   <= data_wr_csr;
                f_mcause <= ecall_NO;
            end
        end
    end

    // strobe monitor, sampled on the falling edge
    int          m_wr_cnt, m_ec_cnt, m_both, m_ready_err;
    logic [11:0] m_wr_addr;
    logic [31:0] m_wr_data, m_ec_no, m_ec_pc;

    always @(negedge clk) begin
        if (wr_en_csr) begin
            m_wr_cnt  = m_wr_cnt + 1;
            m_wr_addr = addr_wr_csr;
            m_wr_data = data_wr_csr;
        end
        if (ecall_en) begin
            m_ec_cnt = m_ec_cnt + 1;
            m_ec_no  = ecall_NO;
            m_ec_pc  = data_wr_csr;
        end
        if (wr_en_csr && ecall_en) m_both = m_both + 1;
    end

    // reference model state and expected results
    logic [31:0] r_mtvec, r_mepc, r_mcause;
    int          e_lat, e_wr_cnt, e_ec_cnt;
    logic [11:0] e_wr_addr;
    logic [31:0] e_wr_data, e_ec_no, e_ec_pc, e_rd_wdata, e_redir_pc;
    logic        e_ill, e_rd_we, e_redir_v;

    // observed response
    int          o_lat, o_wait;
    logic        o_ill, o_rd_we, o_redir_v;
    logic [31:0] o_rd_wdata, o_redir_pc;

    function automatic logic [31:0] ref_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800;
            12'h305: return r_mtvec;
            12'h341: return r_mepc;
            12'h342: return r_mcause;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model(input bit c, input bit e, input bit m, input logic [2:0] f3,
                         input logic [11:0] a, input logic [4:0] ri, input logic [31:0] rs,
                         input logic [31:0] p, input logic [31:0] a5v);
        int nsel;
        bit legal, wr;
        logic [31:0] old, src, nv;
        nsel = int'(c) + int'(e) + int'(m);
        legal = (nsel == 1) && (!c || ((f3 inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7}) &&
                                       (a inside {12'h300, 12'h305, 12'h341, 12'h342})));
        e_lat = 0; e_wr_cnt = 0; e_ec_cnt = 0; e_wr_addr = '0; e_wr_data = '0;
        e_ec_no = '0; e_ec_pc = '0; e_rd_wdata = '0; e_redir_pc = '0;
        e_ill = 1'b0; e_rd_we = 1'b0; e_redir_v = 1'b0;
        if (!legal) begin
            e_ill = 1'b1;
            e_lat = 1;
        end else if (c) begin
            old = ref_read(a);
            src = (f3 >= 3'd5) ? {27'd0, ri} : rs;
            if (f3 == 3'd1 || f3 == 3'd5)      nv = src;
            else if (f3 == 3'd2 || f3 == 3'd6) nv = old | src;
            else                               nv = old & ~src;
            wr = (a != 12'h300) && !((f3 inside {3'd2, 3'd3, 3'd6, 3'd7}) && ri == 5'd0);
            e_lat = wr ? 3 : 2;
            if (wr) begin
                e_wr_cnt = 1; e_wr_addr = a; e_wr_data = nv;
                if (a == 12'h305) r_mtvec = nv;
                if (a == 12'h341) r_mepc = nv;
                if (a == 12'h342) r_mcause = nv;
            end
            e_rd_we = 1'b1;
            e_rd_wdata = old;
        end else if (e) begin
            e_lat = 2; e_ec_cnt = 1; e_ec_no = a5v; e_ec_pc = p;
            e_redir_v = 1'b1; e_redir_pc = r_mtvec;
            r_mepc = p; r_mcause = a5v;
        end else begin
            e_lat = 2; e_redir_v = 1'b1; e_redir_pc = r_mepc;
        end
    endtask

    task automatic preload(input logic [31:0] tv, input logic [31:0] ep, input logic [31:0] mc);
        @(negedge clk);
        pl_mtvec = tv; pl_mepc = ep; pl_mcause = mc; pl_en = 1'b1;
        r_mtvec = tv; r_mepc = ep; r_mcause = mc;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic scramble();
        is_csr = 1'($urandom); is_ecall = 1'($urandom); is_mret = 1'($urandom);
        funct3 = 3'($urandom); csr_addr = 12'($urandom); rs1_idx = 5'($urandom);
        rs1_data = $urandom; pc = $urandom; a5_data = $urandom;
    endtask

    // issue one request and wait (bounded) for its response
    task automatic run_op(input bit c, input bit e, input bit m, input logic [2:0] f3,
                          input logic [11:0] a, input logic [4:0] ri, input logic [31:0] rs,
                          input logic [31:0] p, input logic [31:0] a5v);
        @(negedge clk);
        o_wait = 0;
        while (!req_ready && o_wait < 20) begin
            @(negedge clk);
            o_wait++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_wait got=%b exp=1 after %0d cycles", req_ready, o_wait);
        end
        is_csr = c; is_ecall = e; is_mret = m; funct3 = f3; csr_addr = a;
        rs1_idx = ri; rs1_data = rs; pc = p; a5_data = a5v; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        scramble();
        m_wr_cnt = 0; m_ec_cnt = 0; m_both = 0; m_ready_err = 0;
        m_wr_addr = '0; m_wr_data = '0; m_ec_no = '0; m_ec_pc = '0;
        o_lat = 0;
        do begin
            @(negedge clk);
            o_lat++;
            if (req_ready !== 1'b0) m_ready_err++;
        end while (resp_valid !== 1'b1 && o_lat < 20);
        checks++;
        if (resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL resp_timeout got resp_valid=%b exp=1 within 20 cycles", resp_valid);
        end
        o_ill = illegal; o_rd_we = rd_we; o_rd_wdata = rd_wdata;
        o_redir_v = redir_valid; o_redir_pc = redir_pc;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        scramble();
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, addr_rd_csr, wr_en_csr, addr_wr_csr, data_wr_csr, ecall_en, ecall_NO,
             resp_valid, rd_we, rd_wdata, redir_valid, redir_pc, illegal} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b wr=%b ec=%b rv=%b ill=%b exp=all zero",
                     req_ready, wr_en_csr, ecall_en, resp_valid, illegal);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_csrrw();
        preload(32'h0, 32'h8000_0000, 32'h0);
        model(1, 0, 0, 3'b001, 12'h305, 5'd7, 32'h8000_0100, 32'h0, 32'h0);
        run_op(1, 0, 0, 3'b001, 12'h305, 5'd7, 32'h8000_0100, 32'h0, 32'h0);
        checks++;
        if (o_lat !== 3) begin failures++; $display("FAIL csrrw_lat got=%0d exp=3", o_lat); end
        checks++;
        if ({m_wr_cnt, m_wr_addr, m_wr_data, m_ec_cnt} !== {32'd1, 12'h305, 32'h8000_0100, 32'd0}) begin
            failures++;
            $display("FAIL csrrw_write got cnt=%0d addr=%h data=%h ec=%0d exp cnt=1 addr=305 data=80000100 ec=0",
                     m_wr_cnt, m_wr_addr, m_wr_data, m_ec_cnt);
        end
        checks++;
        if ({o_rd_we, o_rd_wdata, o_ill, o_redir_v} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL csrrw_resp got we=%b rd=%h ill=%b rv=%b exp we=1 rd=0 ill=0 rv=0",
                     o_rd_we, o_rd_wdata, o_ill, o_redir_v);
        end
    endtask

    task automatic test_csrrs_x0();
        preload(32'h8000_1000, 32'h8000_0000, 32'h0000_000b);
        model(1, 0, 0, 3'b010, 12'h342, 5'd0, 32'hffff_ffff, 32'h0, 32'h0);
        run_op(1, 0, 0, 3'b010, 12'h342, 5'd0, 32'hffff_ffff, 32'h0, 32'h0);
        checks++;
        if ({o_lat, m_wr_cnt, o_rd_we, o_rd_wdata} !== {32'd2, 32'd0, 1'b1, 32'h0000_000b}) begin
            failures++;
            $display("FAIL csrrs_x0 got lat=%0d wr=%0d we=%b rd=%h exp lat=2 wr=0 we=1 rd=0000000b",
                     o_lat, m_wr_cnt, o_rd_we, o_rd_wdata);
        end
    endtask

    task automatic test_csrrci_mstatus();
        preload(32'h8000_1000, 32'h8000_0007, 32'h0);
        model(1, 0, 0, 3'b111, 12'h341, 5'd3, 32'h0, 32'h0, 32'h0);
        run_op(1, 0, 0, 3'b111, 12'h341, 5'd3, 32'h0, 32'h0, 32'h0);
        checks++;
        if ({o_lat, m_wr_cnt, m_wr_addr, m_wr_data, o_rd_wdata} !==
            {32'd3, 32'd1, 12'h341, 32'h8000_0004, 32'h8000_0007}) begin
            failures++;
            $display("FAIL csrrci got lat=%0d wr=%0d addr=%h data=%h rd=%h exp lat=3 wr=1 addr=341 data=80000004 rd=80000007",
                     o_lat, m_wr_cnt, m_wr_addr, m_wr_data, o_rd_wdata);
        end
        model(1, 0, 0, 3'b001, 12'h300, 5'd9, 32'h0000_1234, 32'h0, 32'h0);
        run_op(1, 0, 0, 3'b001, 12'h300, 5'd9, 32'h0000_1234, 32'h0, 32'h0);
        checks++;
        if ({o_lat, m_wr_cnt, o_rd_we, o_rd_wdata} !== {32'd2, 32'd0, 1'b1, 32'h0000_1800}) begin
            failures++;
            $display("FAIL csrrw_mstatus got lat=%0d wr=%0d we=%b rd=%h exp lat=2 wr=0 we=1 rd=00001800",
                     o_lat, m_wr_cnt, o_rd_we, o_rd_wdata);
        end
    endtask

    task automatic test_ecall();
        preload(32'h8000_1000, 32'h0, 32'h0);
        model(0, 1, 0, 3'b000, 12'h000, 5'd0, 32'h0, 32'h8000_0040, 32'd11);
        run_op(0, 1, 0, 3'b000, 12'h000, 5'd0, 32'h0, 32'h8000_0040, 32'd11);
        checks++;
        if ({o_lat, m_ec_cnt, m_ec_no, m_ec_pc, m_wr_cnt, m_both} !==
            {32'd2, 32'd1, 32'd11, 32'h8000_0040, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL ecall_strobe got lat=%0d ec=%0d no=%h pc=%h wr=%0d both=%0d exp lat=2 ec=1 no=b pc=80000040 wr=0 both=0",
                     o_lat, m_ec_cnt, m_ec_no, m_ec_pc, m_wr_cnt, m_both);
        end
        checks++;
        if ({o_redir_v, o_redir_pc, o_rd_we, o_ill} !== {1'b1, 32'h8000_1000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL ecall_redir got rv=%b pc=%h we=%b ill=%b exp rv=1 pc=80001000 we=0 ill=0",
                     o_redir_v, o_redir_pc, o_rd_we, o_ill);
        end
    endtask

    task automatic test_mret_hold();
        logic [71:0] snap;
        int diffs;
        preload(32'h8000_1000, 32'h8000_0044, 32'h0);
        model(0, 0, 1, 3'b000, 12'h302, 5'd0, 32'h0, 32'h0, 32'h0);
        resp_ready = 1'b0;
        run_op(0, 0, 1, 3'b000, 12'h302, 5'd0, 32'h0, 32'h0, 32'h0);
        checks++;
        if ({o_lat, o_redir_v, o_redir_pc, o_rd_we, o_ill} !== {32'd2, 1'b1, 32'h8000_0044, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mret_resp got lat=%0d rv=%b pc=%h we=%b ill=%b exp lat=2 rv=1 pc=80000044 we=0 ill=0",
                     o_lat, o_redir_v, o_redir_pc, o_rd_we, o_ill);
        end
        snap = {resp_valid, rd_we, rd_wdata, redir_valid, redir_pc, illegal, wr_en_csr, ecall_en, req_ready};
        diffs = 0;
        repeat (5) begin
            @(negedge clk);
            if ({resp_valid, rd_we, rd_wdata, redir_valid, redir_pc, illegal, wr_en_csr, ecall_en, req_ready} !== snap)
                diffs++;
        end
        checks++;
        if ({diffs, m_wr_cnt, m_ec_cnt, resp_valid, redir_pc} !== {32'd0, 32'd0, 32'd0, 1'b1, 32'h8000_0044}) begin
            failures++;
            $display("FAIL mret_hold got diffs=%0d wr=%0d ec=%0d rv=%b pc=%h exp diffs=0 wr=0 ec=0 rv=1 pc=80000044",
                     diffs, m_wr_cnt, m_ec_cnt, resp_valid, redir_pc);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            failures++;
            $display("FAIL mret_release got rv=%b ready=%b exp rv=0 ready=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_illegal();
        logic [11:0] bad_a [3] = '{12'h7c0, 12'h305, 12'h341};
        logic [2:0]  bad_f [3] = '{3'b001, 3'b100, 3'b010};
        bit          two   [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            model(1, two[i], 0, bad_f[i], bad_a[i], 5'd1, 32'h5, 32'h0, 32'h0);
            run_op(1, two[i], 0, bad_f[i], bad_a[i], 5'd1, 32'h5, 32'h0, 32'h0);
            checks++;
            if ({o_lat, o_ill, o_rd_we, o_redir_v, m_wr_cnt, m_ec_cnt} !==
                {32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
                failures++;
                $display("FAIL illegal_%0d got lat=%0d ill=%b we=%b rv=%b wr=%0d ec=%0d exp lat=1 ill=1 we=0 rv=0 wr=0 ec=0",
                         i, o_lat, o_ill, o_rd_we, o_redir_v, m_wr_cnt, m_ec_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        preload(32'h1111_0000, 32'h2222_0000, 32'h3);
        @(negedge clk);
        is_csr = 1; is_ecall = 0; is_mret = 0; funct3 = 3'b001; csr_addr = 12'h305;
        rs1_idx = 5'd4; rs1_data = 32'hdead_beef; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (wr_en_csr !== 1'b1 && n < 10);
        checks++;
        if (wr_en_csr !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_reach_write got wr_en=%b exp=1", wr_en_csr);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({wr_en_csr, ecall_en, resp_valid, req_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_drop got wr=%b ec=%b rv=%b ready=%b exp all 0",
                     wr_en_csr, ecall_en, resp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, f_mtvec} !== {1'b1, 1'b0, r_mtvec}) begin
            failures++;
            $display("FAIL reset_mid_idle got ready=%b rv=%b mtvec=%h exp ready=1 rv=0 mtvec=%h",
                     req_ready, resp_valid, f_mtvec, r_mtvec);
        end
    endtask

    task automatic test_back_to_back();
        preload(32'h8000_1000, 32'h8000_2000, 32'h7);
        for (int i = 0; i < 4; i++) begin
            model(1, 0, 0, 3'b010, 12'h342, 5'(i + 1), 32'h1 << i, 32'h0, 32'h0);
            run_op(1, 0, 0, 3'b010, 12'h342, 5'(i + 1), 32'h1 << i, 32'h0, 32'h0);
            checks++;
            if ({o_wait, o_lat, o_rd_wdata, m_wr_data} !== {32'd0, e_lat, e_rd_wdata, e_wr_data}) begin
                failures++;
                $display("FAIL back_to_back_%0d got wait=%0d lat=%0d rd=%h wd=%h exp wait=0 lat=%0d rd=%h wd=%h",
                         i, o_wait, o_lat, o_rd_wdata, m_wr_data, e_lat, e_rd_wdata, e_wr_data);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] addrs [4] = '{12'h300, 12'h305, 12'h341, 12'h342};
        logic [2:0]  f3s   [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        bit c, e, m;
        logic [2:0] f3;
        logic [11:0] a;
        logic [4:0] ri;
        logic [31:0] rs, p, a5v;
        int k;
        preload($urandom, $urandom, $urandom);
        for (int t = 0; t < 200; t++) begin
            c = 0; e = 0; m = 0; f3 = 3'd0; a = 12'h000;
            k = $urandom_range(0, 99);
            if (k < 60) begin
                c = 1; a = addrs[$urandom_range(0, 3)]; f3 = f3s[$urandom_range(0, 5)];
            end else if (k < 72) begin
                e = 1;
            end else if (k < 82) begin
                m = 1; a = 12'h302;
            end else begin
                case ($urandom_range(0, 3))
                    0: begin c = 1; a = 12'($urandom); f3 = f3s[$urandom_range(0, 5)]; end
                    1: begin c = 1; a = addrs[$urandom_range(0, 3)]; f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd4; end
                    2: begin c = 1'($urandom); e = 1; m = 1; end
                    default: ;
                endcase
            end
            ri  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs  = $urandom; p = $urandom; a5v = $urandom;
            model(c, e, m, f3, a, ri, rs, p, a5v);
            run_op(c, e, m, f3, a, ri, rs, p, a5v);
            checks++;
            if (o_lat !== e_lat) begin
                failures++;
                $display("FAIL rnd%0d_latency got=%0d exp=%0d", t, o_lat, e_lat);
            end
            checks++;
            if ({m_wr_cnt, m_wr_addr, m_wr_data, m_ec_cnt, m_ec_no, m_ec_pc, m_both, m_ready_err} !==
                {e_wr_cnt, e_wr_addr, e_wr_data, e_ec_cnt, e_ec_no, e_ec_pc, 32'd0, 32'd0}) begin
                failures++;
                $display("FAIL rnd%0d_strobes got wr=%0d@%h=%h ec=%0d no=%h pc=%h both=%0d rdy=%0d exp wr=%0d@%h=%h ec=%0d no=%h pc=%h both=0 rdy=0",
                         t, m_wr_cnt, m_wr_addr, m_wr_data, m_ec_cnt, m_ec_no, m_ec_pc, m_both, m_ready_err,
                         e_wr_cnt, e_wr_addr, e_wr_data, e_ec_cnt, e_ec_no, e_ec_pc);
            end
            checks++;
            if ({o_ill, o_rd_we, (e_rd_we ? o_rd_wdata : 32'h0), o_redir_v, (e_redir_v ? o_redir_pc : 32'h0)} !==
                {e_ill, e_rd_we, e_rd_wdata, e_redir_v, e_redir_pc}) begin
                failures++;
                $display("FAIL rnd%0d_resp got ill=%b we=%b rd=%h rv=%b pc=%h exp ill=%b we=%b rd=%h rv=%b pc=%h",
                         t, o_ill, o_rd_we, o_rd_wdata, o_redir_v, o_redir_pc,
                         e_ill, e_rd_we, e_rd_wdata, e_redir_v, e_redir_pc);
            end
        end
        @(negedge clk);
        checks++;
        if ({f_mtvec, f_mepc, f_mcause} !== {r_mtvec, r_mepc, r_mcause}) begin
            failures++;
            $display("FAIL rnd_csr_state got %h %h %h exp %h %h %h",
                     f_mtvec, f_mepc, f_mcause, r_mtvec, r_mepc, r_mcause);
        end
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_csrrs_x0();
        test_csrrci_mstatus();
        test_ecall();
        test_mret_hold();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
